// File: rtl/trk_loop_ctrl.sv
// Per-channel tracking-loop sequencer: hands acquisition FCWs to the NCOs,
// sequences the loop filter through pull-in and track, and detects lock loss.
module trk_loop_ctrl #(
    parameter logic [31:0] LOCK_TH    = 32'd4096,
    parameter logic [31:0] UNLOCK_TH  = 32'd16384,
    parameter int unsigned LOCK_CNT   = 16,
    parameter int unsigned UNLOCK_CNT = 8,
    parameter int unsigned PULLIN_MAX = 1000,
    parameter int unsigned CNT_W      = 16
) (
    input  logic        rx_clk,
    input  logic        rx_rst_n,
    input  logic        acq_valid,
    input  logic [31:0] acq_car_fcw,
    input  logic [31:0] acq_prn_fcw,
    input  logic        trk_abort,
    input  logic        rx_prn_sop,
    input  logic [31:0] rx_pll_disc,
    input  logic [31:0] lpf_car_fcw,
    input  logic [31:0] lpf_prn_fcw,
    output logic        lpf_rst,
    output logic        lpf_sop,
    output logic        bw_sel,
    output logic [31:0] tx_car_fcw,
    output logic [31:0] tx_prn_fcw,
    output logic [2:0]  trk_state,
    output logic        lock_flag,
    output logic        lol_pulse
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_PULLIN = 3'd2,
        ST_TRACK  = 3'd3,
        ST_LOST   = 3'd4
    } state_e;

    localparam logic [CNT_W-1:0] LOCK_CNT_C   = CNT_W'(LOCK_CNT);
    localparam logic [CNT_W-1:0] UNLOCK_CNT_C = CNT_W'(UNLOCK_CNT);
    localparam logic [CNT_W-1:0] PULLIN_MAX_C = CNT_W'(PULLIN_MAX);

    state_e            state_q, state_d;
    logic [31:0]       base_car_q, base_car_d;
    logic [31:0]       base_prn_q, base_prn_d;
    logic [CNT_W-1:0]  epoch_cnt_q, epoch_cnt_d;
    logic [CNT_W-1:0]  good_cnt_q, good_cnt_d;
    logic [CNT_W-1:0]  bad_cnt_q, bad_cnt_d;
    logic              sop_q;
    logic [31:0]       tx_car_q, tx_car_d;
    logic [31:0]       tx_prn_q, tx_prn_d;
    logic [31:0]       disc_abs;

    // Magnitude of a signed discriminator; the most negative value saturates.
    function automatic logic [31:0] abs_sat(input logic signed [31:0] v);
        if (v == {1'b1, 31'b0})
            return 32'h7FFF_FFFF;
        else if (v[31])
            return $unsigned(-v);
        else
            return $unsigned(v);
    endfunction

    // Epoch counters stick at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // Control outputs decoded straight from the state register.
    assign lpf_rst   = !((state_q == ST_PULLIN) || (state_q == ST_TRACK));
    assign lpf_sop   = sop_q && ((state_q == ST_PULLIN) || (state_q == ST_TRACK));
    assign bw_sel    = (state_q == ST_TRACK);
    assign lock_flag = (state_q == ST_TRACK);
    assign lol_pulse = (state_q == ST_LOST);
    assign trk_state = state_q;
    assign tx_car_fcw = tx_car_q;
    assign tx_prn_fcw = tx_prn_q;

    // Next-state, base latching and epoch counter update.
    always_comb begin
        state_d     = state_q;
        base_car_d  = base_car_q;
        base_prn_d  = base_prn_q;
        epoch_cnt_d = epoch_cnt_q;
        good_cnt_d  = good_cnt_q;
        bad_cnt_d   = bad_cnt_q;
        disc_abs    = abs_sat(rx_pll_disc);

        if (trk_abort) begin
            // Abort beats everything, including a same-cycle acq_valid.
            state_d     = ST_IDLE;
            epoch_cnt_d = '0;
            good_cnt_d  = '0;
            bad_cnt_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (acq_valid) begin
                        base_car_d = acq_car_fcw;
                        base_prn_d = acq_prn_fcw;
                        state_d    = ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    epoch_cnt_d = '0;
                    good_cnt_d  = '0;
                    bad_cnt_d   = '0;
                    state_d     = ST_PULLIN;
                end
                ST_PULLIN: begin
                    if (rx_prn_sop) begin
                        epoch_cnt_d = sat_inc(epoch_cnt_q);
                        good_cnt_d  = (disc_abs < LOCK_TH) ? sat_inc(good_cnt_q) : '0;
                        // Lock takes precedence over an expiring budget.
                        if (good_cnt_d >= LOCK_CNT_C)
                            state_d = ST_TRACK;
                        else if (epoch_cnt_d >= PULLIN_MAX_C)
                            state_d = ST_LOST;
                    end
                end
                ST_TRACK: begin
                    if (rx_prn_sop) begin
                        bad_cnt_d = (disc_abs > UNLOCK_TH) ? sat_inc(bad_cnt_q) : '0;
                        if (bad_cnt_d >= UNLOCK_CNT_C)
                            state_d = ST_LOST;
                    end
                end
                ST_LOST: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        // Filter corrections only count once the filter is out of reset.
        tx_car_d = base_car_q + (lpf_rst ? 32'd0 : lpf_car_fcw);
        tx_prn_d = base_prn_q + (lpf_rst ? 32'd0 : lpf_prn_fcw);
    end

    // State, base, counter and output registers.
    always_ff @(posedge rx_clk or negedge rx_rst_n) begin
        if (!rx_rst_n) begin
            state_q     <= ST_IDLE;
            base_car_q  <= '0;
            base_prn_q  <= '0;
            epoch_cnt_q <= '0;
            good_cnt_q  <= '0;
            bad_cnt_q   <= '0;
            sop_q       <= 1'b0;
            tx_car_q    <= '0;
            tx_prn_q    <= '0;
        end else begin
            state_q     <= state_d;
            base_car_q  <= base_car_d;
            base_prn_q  <= base_prn_d;
            epoch_cnt_q <= epoch_cnt_d;
            good_cnt_q  <= good_cnt_d;
            bad_cnt_q   <= bad_cnt_d;
            sop_q       <= rx_prn_sop;
            tx_car_q    <= tx_car_d;
            tx_prn_q    <= tx_prn_d;
        end
    end

endmodule

// File: tb/tb_trk_loop_ctrl.sv
// Directed bench for trk_loop_ctrl: handover, lock, timeout, loss of lock,
// FCW wrap, abort priority and asynchronous reset.
module tb_trk_loop_ctrl;

    logic        rx_clk = 1'b0;
    logic        rx_rst_n;
    logic        acq_valid;
    logic [31:0] acq_car_fcw;
    logic [31:0] acq_prn_fcw;
    logic        trk_abort;
    logic        rx_prn_sop;
    logic [31:0] rx_pll_disc;
    logic [31:0] lpf_car_fcw;
    logic [31:0] lpf_prn_fcw;
    logic        lpf_rst;
    logic        lpf_sop;
    logic        bw_sel;
    logic [31:0] tx_car_fcw;
    logic [31:0] tx_prn_fcw;
    logic [2:0]  trk_state;
    logic        lock_flag;
    logic        lol_pulse;

    int n_cmp = 0;
    int n_err = 0;

    trk_loop_ctrl dut (
        .rx_clk      (rx_clk),
        .rx_rst_n    (rx_rst_n),
        .acq_valid   (acq_valid),
        .acq_car_fcw (acq_car_fcw),
        .acq_prn_fcw (acq_prn_fcw),
        .trk_abort   (trk_abort),
        .rx_prn_sop  (rx_prn_sop),
        .rx_pll_disc (rx_pll_disc),
        .lpf_car_fcw (lpf_car_fcw),
        .lpf_prn_fcw (lpf_prn_fcw),
        .lpf_rst     (lpf_rst),
        .lpf_sop     (lpf_sop),
        .bw_sel      (bw_sel),
        .tx_car_fcw  (tx_car_fcw),
        .tx_prn_fcw  (tx_prn_fcw),
        .trk_state   (trk_state),
        .lock_flag   (lock_flag),
        .lol_pulse   (lol_pulse)
    );

    always #5 rx_clk = ~rx_clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic tick();
        @(posedge rx_clk);
        #1;
    endtask

    // One epoch strobe carrying the given discriminator.
    task automatic epoch(input logic [31:0] disc);
        rx_prn_sop  = 1'b1;
        rx_pll_disc = disc;
        tick();
        rx_prn_sop  = 1'b0;
    endtask

    task automatic epochs(input int n, input logic [31:0] disc);
        for (int i = 0; i < n; i++) epoch(disc);
    endtask

    task automatic handover(input logic [31:0] car, input logic [31:0] prn);
        acq_valid   = 1'b1;
        acq_car_fcw = car;
        acq_prn_fcw = prn;
        tick();
        acq_valid   = 1'b0;
    endtask

    initial begin
        rx_rst_n    = 1'b0;
        acq_valid   = 1'b0;
        acq_car_fcw = '0;
        acq_prn_fcw = '0;
        trk_abort   = 1'b0;
        rx_prn_sop  = 1'b0;
        rx_pll_disc = '0;
        lpf_car_fcw = '0;
        lpf_prn_fcw = '0;
        tick();
        tick();
        chk("rst_state",   32'(trk_state), 32'd0);
        chk("rst_lpf_rst", 32'(lpf_rst),   32'd1);
        chk("rst_lpf_sop", 32'(lpf_sop),   32'd0);
        chk("rst_bw_sel",  32'(bw_sel),    32'd0);
        chk("rst_lock",    32'(lock_flag), 32'd0);
        chk("rst_lol",     32'(lol_pulse), 32'd0);
        chk("rst_tx_car",  tx_car_fcw,     32'd0);
        chk("rst_tx_prn",  tx_prn_fcw,     32'd0);
        rx_rst_n = 1'b1;
        tick();

        // 1. Handover IDLE -> LOAD -> PULLIN
        handover(32'h1000_0000, 32'h0200_0000);
        chk("t1_load_state",   32'(trk_state), 32'd1);
        chk("t1_load_lpf_rst", 32'(lpf_rst),   32'd1);
        tick();
        chk("t1_pullin_state", 32'(trk_state), 32'd2);
        chk("t1_pullin_rst",   32'(lpf_rst),   32'd0);
        chk("t1_pullin_bw",    32'(bw_sel),    32'd0);
        chk("t1_tx_car",       tx_car_fcw,     32'h1000_0000);
        chk("t1_tx_prn",       tx_prn_fcw,     32'h0200_0000);
        // acq_valid outside IDLE must not reload the bases
        handover(32'h5555_0000, 32'h6666_0000);
        tick();
        chk("t1_acq_ignored_state", 32'(trk_state), 32'd2);
        chk("t1_acq_ignored_car",   tx_car_fcw,     32'h1000_0000);

        // 2. Pull-in lock with a restart at epoch 10
        epochs(9, 32'd100);
        epoch(32'hFFFF_EC78);            // -5000
        epochs(15, 32'd100);
        chk("t2_ep25_state", 32'(trk_state), 32'd2);
        chk("t2_ep25_sop",   32'(lpf_sop),   32'd1);
        epoch(32'd100);
        chk("t2_lock_state", 32'(trk_state), 32'd3);
        chk("t2_lock_bw",    32'(bw_sel),    32'd1);
        chk("t2_lock_flag",  32'(lock_flag), 32'd1);
        chk("t2_lock_sop",   32'(lpf_sop),   32'd1);
        tick();
        chk("t2_sop_idle",   32'(lpf_sop),   32'd0);

        // 4. Loss of lock in TRACK; magnitude exactly at threshold is not bad
        for (int i = 0; i < 5; i++) begin
            epoch(32'd16384);
            epoch(32'hFFFF_C000);        // -16384
        end
        chk("t4_th_edge_state", 32'(trk_state), 32'd3);
        epochs(7, 32'd20000);
        chk("t4_bad7_state", 32'(trk_state), 32'd3);
        epoch(32'd0);
        epochs(7, 32'd20000);
        chk("t4_bad7b_state", 32'(trk_state), 32'd3);
        epoch(32'h8000_0000);            // -2^31 counts as bad
        chk("t4_lost_state", 32'(trk_state), 32'd4);
        chk("t4_lost_lol",   32'(lol_pulse), 32'd1);
        chk("t4_lost_rst",   32'(lpf_rst),   32'd1);
        chk("t4_lost_lock",  32'(lock_flag), 32'd0);
        chk("t4_lost_sop",   32'(lpf_sop),   32'd0);
        tick();
        chk("t4_idle_state", 32'(trk_state), 32'd0);
        chk("t4_idle_lol",   32'(lol_pulse), 32'd0);

        // 3. Pull-in timeout; magnitude exactly at LOCK_TH is not good
        handover(32'h1000_0000, 32'h0200_0000);
        tick();
        epochs(20, 32'd4096);
        chk("t3_th_edge_state", 32'(trk_state), 32'd2);
        epochs(979, 32'd8000);
        chk("t3_ep999_state", 32'(trk_state), 32'd2);
        epoch(32'd8000);
        chk("t3_lost_state", 32'(trk_state), 32'd4);
        chk("t3_lost_lol",   32'(lol_pulse), 32'd1);
        tick();
        chk("t3_idle_state", 32'(trk_state), 32'd0);
        chk("t3_idle_lol",   32'(lol_pulse), 32'd0);
        chk("t3_idle_rst",   32'(lpf_rst),   32'd1);

        // 5. Modulo FCW sum, then abort in TRACK together with a strobe
        lpf_car_fcw = 32'h0000_0020;
        lpf_prn_fcw = 32'h0000_0005;
        handover(32'hFFFF_FFF0, 32'h0000_0100);
        tick();
        chk("t5_base_car", tx_car_fcw, 32'hFFFF_FFF0);
        tick();
        chk("t5_wrap_car", tx_car_fcw, 32'h0000_0010);
        chk("t5_sum_prn",  tx_prn_fcw, 32'h0000_0105);
        epochs(16, 32'd0);
        chk("t5_track_state", 32'(trk_state), 32'd3);
        trk_abort = 1'b1;
        epoch(32'd20000);
        trk_abort = 1'b0;
        chk("t5_abort_state", 32'(trk_state), 32'd0);
        chk("t5_abort_lol",   32'(lol_pulse), 32'd0);
        chk("t5_abort_sop",   32'(lpf_sop),   32'd0);
        tick();
        chk("t5_base_kept",   tx_car_fcw,     32'hFFFF_FFF0);
        trk_abort = 1'b1;
        handover(32'h1000_0000, 32'h0200_0000);
        trk_abort = 1'b0;
        chk("t5_abort_acq_state", 32'(trk_state), 32'd0);
        tick();
        chk("t5_abort_acq_state2", 32'(trk_state), 32'd0);

        // 6. Asynchronous reset mid-PULLIN
        handover(32'h1000_0000, 32'h0200_0000);
        tick();
        epochs(5, 32'd0);
        tick();
        chk("t6_pre_state", 32'(trk_state), 32'd2);
        chk("t6_pre_car",   tx_car_fcw,     32'h1000_0020);
        #2;
        rx_rst_n = 1'b0;
        #1;
        chk("t6_state",   32'(trk_state), 32'd0);
        chk("t6_lpf_rst", 32'(lpf_rst),   32'd1);
        chk("t6_tx_car",  tx_car_fcw,     32'd0);
        chk("t6_tx_prn",  tx_prn_fcw,     32'd0);
        tick();
        rx_rst_n = 1'b1;
        tick();
        chk("t6_after_state", 32'(trk_state), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
